// File: rtl/ref_updown_ctrl.sv
// ref_updown_ctrl: debounced up/down push-button control of a saturating reference value.
module ref_updown_ctrl #(
  parameter int RESOLUTION_BITS = 8,
  parameter int INIT_VALUE      = 128,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_BITS   = 20,
  parameter int HOLD_BITS       = 24,
  parameter int REPEAT_BITS     = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sum,
  input  logic                       rest,
  output logic [RESOLUTION_BITS-1:0] ref_out,
  output logic                       upd,
  output logic                       sum_db,
  output logic                       rest_db
);
  localparam int RB = RESOLUTION_BITS;
  localparam int DB = DEBOUNCE_BITS;
  localparam int CW = (HOLD_BITS > REPEAT_BITS) ? HOLD_BITS : REPEAT_BITS;
  localparam logic [DB-1:0] DB_TERM = DB'((2 ** DB) - 2);
  localparam logic [RB:0]   STEP_W  = (RB + 1)'(STEP);
  localparam logic [RB-1:0] MAX_V   = {RB{1'b1}};
  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;
  state_t state_q, state_d;
  logic [1:0] s1_q, s1_d, s2_q, s2_d, db_q, db_d;
  logic [DB-1:0] dcnt_q [2];
  logic [DB-1:0] dcnt_d [2];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RB-1:0] ref_q, ref_d;
  logic [RB:0] inc_w, dec_w;
  logic dir_q, dir_d, upd_q, upd_d, up, dn, step;
  always_comb begin
    s1_d = {rest, sum};
    s2_d = s1_q;
    for (int i = 0; i < 2; i++) begin
      // Flip one count early so the level changes on the edge the count would hit all-ones.
      db_d[i]   = (s2_q[i] != db_q[i] && dcnt_q[i] == DB_TERM) ? ~db_q[i] : db_q[i];
      dcnt_d[i] = (s2_q[i] == db_q[i] || dcnt_q[i] == DB_TERM) ? '0 : dcnt_q[i] + DB'(1);
    end
    up      = !db_q[0] && db_q[1];
    dn      = !db_q[1] && db_q[0];
    step    = 1'b0;
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (up || dn) begin
          step    = 1'b1;
          state_d = HOLD;
          dir_d   = up;
        end
      end
      HOLD: begin
        if (!(dir_q ? up : dn)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q[HOLD_BITS-1:0] == '1) begin
          step    = 1'b1;
          state_d = RPT;
          cnt_d   = '0;
        end
      end
      RPT: begin
        if (!(dir_q ? up : dn)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q[REPEAT_BITS-1:0] == '1) begin
          step  = 1'b1;
          cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    inc_w = {1'b0, ref_q} + STEP_W;
    dec_w = {1'b0, ref_q} - STEP_W;
    ref_d = !step ? ref_q : dir_d ? (inc_w > {1'b0, MAX_V} ? MAX_V : inc_w[RB-1:0])
                                  : (dec_w[RB] ? '0 : dec_w[RB-1:0]);
    upd_d = ref_d != ref_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= 2'b11;
      s2_q    <= 2'b11;
      db_q    <= 2'b11;
      dcnt_q  <= '{default: '0};
      cnt_q   <= '0;
      state_q <= IDLE;
      dir_q   <= 1'b0;
      ref_q   <= RB'(INIT_VALUE);
      upd_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      ref_q   <= ref_d;
      upd_q   <= upd_d;
    end
  end
  assign ref_out = ref_q;
  assign upd     = upd_q;
  assign sum_db  = db_q[0];
  assign rest_db = db_q[1];
endmodule
